// File: rtl/lcd_message_sequencer.sv
// Streams a 32-character, two-line text buffer into a character LCD write controller,
// inserting the line 1 / line 2 DDRAM address commands and honouring the write/ready handshake.
module lcd_message_sequencer #(
  parameter int unsigned REFRESH_CYCLES = 32'd5_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iBufWrEn,
  input  logic [4:0] iBufWrAddr,
  input  logic [7:0] iBufWrData,
  input  logic       iStart,
  input  logic       iReady,
  output logic       oWrite,
  output logic [7:0] oData,
  output logic       oCommand,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  localparam logic [5:0] LastItem  = 6'd33;
  localparam logic [5:0] Line2Item = 6'd17;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  data_q, data_d;
  logic        cmd_q, cmd_d;
  logic        done_q, done_d;
  logic [7:0]  buf_q [32];

  logic        expire;
  logic        go;
  logic [4:0]  rd_addr;
  logic [7:0]  item_byte;
  logic        item_cmd;

  assign expire = (REFRESH_CYCLES != 32'd0) && (timer_q == REFRESH_CYCLES - 32'd1);
  assign go     = iStart | expire;

  // Items 1..16 map to buffer 0..15, items 18..33 to 16..31; modulo-32 subtraction covers both.
  always_comb begin
    rd_addr   = idx_q[4:0] - ((idx_q <= 6'd16) ? 5'd1 : 5'd2);
    item_cmd  = 1'b0;
    item_byte = buf_q[rd_addr];
    if (idx_q == 6'd0) begin
      item_cmd  = 1'b1;
      item_byte = 8'h80;
    end else if (idx_q == Line2Item) begin
      item_cmd  = 1'b1;
      item_byte = 8'hC0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    oWrite  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go || pend_q) begin
          idx_d   = 6'd0;
          pend_d  = 1'b0;
          timer_d = 32'd0;
          state_d = StFetch;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StFetch: begin
        data_d  = item_byte;
        cmd_d   = item_cmd;
        state_d = StIssue;
      end
      StIssue: begin
        if (iReady) begin
          oWrite  = 1'b1;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!iReady) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (iReady) begin
          if (idx_q == LastItem) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Requests arriving mid-pass collapse into a single follow-up pass.
    if (state_q != StIdle && go) pend_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      idx_q   <= 6'd0;
      pend_q  <= 1'b0;
      timer_q <= 32'd0;
      data_q  <= 8'h00;
      cmd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (iBufWrEn) begin
      buf_q[iBufWrAddr] <= iBufWrData;
    end
  end

  assign oData    = data_q;
  assign oCommand = cmd_q;
  assign oBusy    = (state_q != StIdle);
  assign oDone    = done_q;

endmodule

// File: tb/tb_lcd_message_sequencer.sv
// Randomized bench for lcd_message_sequencer: a latency-programmable LCD controller model drives
// iReady, and every observed write stream is compared to the item list derived from a buffer model.
module tb_lcd_message_sequencer;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset = 1'b1;
  logic       buf_wr_en = 1'b0;
  logic [4:0] buf_wr_addr = 5'd0;
  logic [7:0] buf_wr_data = 8'd0;
  logic       start = 1'b0;
  logic       start_r = 1'b0;
  logic       stuck = 1'b0;

  logic        rdy_q = 1'b1, rdy_r_q = 1'b1;
  int unsigned lat = 10, bcnt = 0, bcnt_r = 0;
  logic        ready, ready_r;
  logic        wr, cmd, busy, done;
  logic [7:0]  data;
  logic        wr_r, cmd_r, busy_r, done_r;
  logic [7:0]  data_r;

  assign ready   = rdy_q & ~stuck;
  assign ready_r = rdy_r_q;

  lcd_message_sequencer #(.REFRESH_CYCLES(0)) dut (
    .Clock(Clock), .Reset(Reset), .iBufWrEn(buf_wr_en), .iBufWrAddr(buf_wr_addr),
    .iBufWrData(buf_wr_data), .iStart(start), .iReady(ready), .oWrite(wr), .oData(data),
    .oCommand(cmd), .oBusy(busy), .oDone(done)
  );

  lcd_message_sequencer #(.REFRESH_CYCLES(100)) dut_r (
    .Clock(Clock), .Reset(Reset), .iBufWrEn(buf_wr_en), .iBufWrAddr(buf_wr_addr),
    .iBufWrData(buf_wr_data), .iStart(start_r), .iReady(ready_r), .oWrite(wr_r),
    .oData(data_r), .oCommand(cmd_r), .oBusy(busy_r), .oDone(done_r)
  );

  // Controller models: an accepted write drops ready for 'lat' clocks (one clock for dut_r).
  always @(posedge Clock) begin
    if (wr && rdy_q) begin
      rdy_q <= 1'b0;
      bcnt  <= lat - 1;
    end else if (!rdy_q) begin
      if (bcnt == 0) rdy_q <= 1'b1;
      else bcnt <= bcnt - 1;
    end
  end

  always @(posedge Clock) begin
    if (wr_r && rdy_r_q) begin
      rdy_r_q <= 1'b0;
      bcnt_r  <= 0;
    end else if (!rdy_r_q) begin
      if (bcnt_r == 0) rdy_r_q <= 1'b1;
      else bcnt_r <= bcnt_r - 1;
    end
  end

  // Monitors sample on the falling edge.
  logic [8:0] wq[$];
  logic [8:0] wq_r[$];
  int         gaps[$];
  int         n_done = 0, n_done_r = 0, gap_r = 0;

  always @(negedge Clock) begin
    if (wr) wq.push_back({cmd, data});
    if (wr_r) wq_r.push_back({cmd_r, data_r});
    if (done) n_done <= n_done + 1;
    if (done_r) n_done_r <= n_done_r + 1;
    if (busy_r) begin
      if (gap_r != 0) gaps.push_back(gap_r);
      gap_r <= 0;
    end else begin
      gap_r <= gap_r + 1;
    end
  end

  int passed = 0, total = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  logic [7:0] mbuf [32];
  logic [7:0] snap [32];

  function automatic logic [8:0] exp_item(input int k);
    if (k == 0) return {1'b1, 8'h80};
    if (k == 17) return {1'b1, 8'hC0};
    if (k <= 16) return {1'b0, snap[k-1]};
    return {1'b0, snap[k-2]};
  endfunction

  task automatic check_pass(input string tag, input int base);
    logic [8:0] obs;
    for (int k = 0; k < 34; k++) begin
      obs = (base + k < wq.size()) ? wq[base+k] : 9'h1ff;
      check_eq($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(exp_item(k)));
    end
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clock);
    buf_wr_en = 1'b1;
    buf_wr_addr = a;
    buf_wr_data = d;
    mbuf[a] = d;
    @(negedge Clock);
    buf_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int i = 0; i < bound && n_done < target; i++) @(posedge Clock);
    check_eq("done_count", n_done, target);
  endtask

  task automatic take_snap();
    for (int i = 0; i < 32; i++) snap[i] = mbuf[i];
  endtask

  initial begin
    int base, d0, wbase;
    logic [7:0] oldv, newv;
    logic [7:0] hello [5];
    logic [7:0] world [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;

    // Reset values
    #1 Reset = 1'b0;
    #11;
    check_eq("rst_write", 32'(wr), 0);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_cmd", 32'(cmd), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    @(negedge Clock);
    Reset = 1'b1;

    // Full pass with start-up timing
    for (int i = 0; i < 5; i++) write_buf(5'(i), hello[i]);
    for (int i = 0; i < 5; i++) write_buf(5'(16 + i), world[i]);
    take_snap();
    base = wq.size();
    d0 = n_done;
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1 check_eq("start_busy", 32'(busy), 1);
    @(negedge Clock);
    start = 1'b0;
    @(posedge Clock);
    #1;
    check_eq("first_data", 32'(data), 32'h80);
    check_eq("first_cmd", 32'(cmd), 1);
    check_eq("first_write", 32'(wr), 1);
    wait_done(d0 + 1, 2000);
    #1 check_eq("end_busy", 32'(busy), 0);
    check_eq("pass_len", wq.size() - base, 34);
    check_pass("hello", base);

    // Randomized passes
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 12);
      for (int j = 0; j < 6; j++) write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
      take_snap();
      base = wq.size();
      d0 = n_done;
      pulse_start();
      wait_done(d0 + 1, 3000);
      check_pass($sformatf("rand%0d", r), base);
    end

    // Handshake hold: buffer[1] changes while item 2 is in flight
    lat = 10;
    take_snap();
    oldv = mbuf[1];
    do newv = 8'($urandom_range(33, 126)); while (newv == oldv);
    base = wq.size();
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 1000 && wq.size() < base + 3; i++) @(posedge Clock);
    write_buf(5'd1, newv);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check_eq("hold_data", 32'(data), 32'(oldv));
      check_eq("hold_cmd", 32'(cmd), 0);
    end
    wait_done(d0 + 1, 2000);
    check_pass("hold_old", base);
    take_snap();
    base = wq.size();
    pulse_start();
    wait_done(d0 + 2, 2000);
    check_pass("hold_new", base);

    // Pending collapse: three requests during a pass give one extra pass
    lat = $urandom_range(3, 6);
    take_snap();
    base = wq.size();
    d0 = n_done;
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(20, 40)) @(negedge Clock);
      pulse_start();
    end
    wait_done(d0 + 2, 4000);
    repeat (400) @(posedge Clock);
    check_eq("pend_dones", n_done, d0 + 2);
    check_eq("pend_writes", wq.size() - base, 68);
    check_pass("pend_a", base);
    check_pass("pend_b", base + 34);

    // REFRESH_CYCLES=0: no pass without a start request
    base = wq.size();
    d0 = n_done;
    repeat (300) @(posedge Clock);
    check_eq("norefresh_writes", wq.size() - base, 0);
    check_eq("norefresh_done", n_done, d0);
    #1 check_eq("norefresh_busy", 32'(busy), 0);

    // Auto-refresh every 100 idle clocks
    @(posedge Clock);
    gaps.delete();
    for (int i = 0; i < 3000 && gaps.size() < 3; i++) @(posedge Clock);
    check_eq("refresh_gap1", (gaps.size() > 1) ? gaps[1] : -1, 100);
    check_eq("refresh_gap2", (gaps.size() > 2) ? gaps[2] : -1, 100);
    check_eq("refresh_first", (wq_r.size() > 0) ? 32'(wq_r[0]) : 32'h1ff, 32'h180);
    check_eq("refresh_done_seen", 32'(n_done_r >= 2), 1);

    // Reset in the middle of a pass
    lat = $urandom_range(2, 8);
    for (int j = 0; j < 6; j++) write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
    base = wq.size();
    pulse_start();
    for (int i = 0; i < 2000 && wq.size() < base + 21; i++) @(posedge Clock);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check_eq("midrst_write", 32'(wr), 0);
    check_eq("midrst_data", 32'(data), 0);
    check_eq("midrst_cmd", 32'(cmd), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_done", 32'(done), 0);
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    wbase = wq.size();
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    repeat (20) @(posedge Clock);
    check_eq("midrst_no_spurious", wq.size() - wbase, 0);
    take_snap();
    base = wq.size();
    d0 = n_done;
    pulse_start();
    wait_done(d0 + 1, 2000);
    check_pass("after_rst", base);

    // Ready stuck low: waits in ISSUE indefinitely
    @(negedge Clock);
    stuck = 1'b1;
    base = wq.size();
    d0 = n_done;
    pulse_start();
    repeat (200) @(posedge Clock);
    #1;
    check_eq("stuck_writes", wq.size() - base, 0);
    check_eq("stuck_write", 32'(wr), 0);
    check_eq("stuck_data", 32'(data), 32'h80);
    check_eq("stuck_cmd", 32'(cmd), 1);
    check_eq("stuck_busy", 32'(busy), 1);
    @(negedge Clock);
    stuck = 1'b0;
    wait_done(d0 + 1, 2000);
    check_pass("unstuck", base);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_message_sequencer.md
# lcd_message_sequencer

Streams a 32-character, two-line text buffer into the character LCD write controller through its write/ready handshake. Inserts the DDRAM address commands for line 1 (0x80) and line 2 (0xC0), and holds byte and command flag stable for the whole write. Sits between host logic, which fills the buffer and requests refreshes, and the LCD controller, which owns LCD pin timing.

## Interface

Parameters:
- REFRESH_CYCLES, default 32'd5_000_000: automatic refresh period in clocks; 0 disables auto-refresh.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset; one clock; asserting it (low) clears all state immediately.
- iBufWrEn  input  1  buffer write strobe.
- iBufWrAddr  input  5  buffer address; 0–15 is line 1, 16–31 is line 2.
- iBufWrData  input  8  ASCII byte to store.
- iStart  input  1  request one full-screen pass; level sampled every clock.
- iReady  input  1  LCD controller ready (idle, accepting a write).
- oWrite  output  1  one-cycle write request to the LCD controller.
- oData  output  8  byte to the LCD controller; held stable from the oWrite cycle until iReady returns high.
- oCommand  output  1  1 means oData is an instruction (RS=0); 0 means character data (RS=1).
- oBusy  output  1  high while a pass is in progress.
- oDone  output  1  one-cycle pulse when a pass completes.

## Operation

- Buffer: 32×8 register array. Every entry resets to 0x20 (space). Host writes are accepted on any clock, including mid-pass.
- Item sequence per pass, 34 items, index 0..33:
  - 0 is command 0x80.
  - 1..16 are buffer[0..15].
  - 17 is command 0xC0.
  - 18..33 are buffer[16..31].
- Item index register: 6 bits, counts 0..33, cleared at pass start. It never wraps past 33.
- FSM states:
  - IDLE: oBusy=0. If iStart=1, or the refresh timer expired, or the pending flag is set: clear index, clear pending, go to FETCH.
  - FETCH: register the next item's byte and command flag into oData/oCommand, then go to ISSUE.
  - ISSUE: wait for iReady=1. Assert oWrite=1 for exactly that cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for iReady=0 (the controller accepted the write), then go to WAIT_DONE.
  - WAIT_DONE: wait for iReady=1. If index=33: pulse oDone and go to IDLE. Otherwise increment index and go to FETCH.
- Pending start: iStart=1 or refresh expiry in any state other than IDLE sets a 1-bit pending flag. Multiple requests collapse to one extra pass.
- Refresh timer: 32-bit counter, increments only in IDLE. It reloads to 0 when a pass starts. Expiry occurs when the count reaches REFRESH_CYCLES−1 and REFRESH_CYCLES≠0.
- Buffer/fetch collision: a host write to the address being fetched in the same cycle gives FETCH the old value. The new value appears on the next pass.
- oData/oCommand are not modified in WAIT_BUSY or WAIT_DONE.

## Timing

- Reset values: oWrite=0, oData=8'h00, oCommand=0, oBusy=0, oDone=0, state=IDLE, index=0, pending=0, timer=0, buffer=0x20.
- iStart high at rising edge N, in IDLE:
  - oBusy=1 and FETCH after edge N.
  - oData=0x80 and oCommand=1 after edge N+1.
  - oWrite=1 in the cycle after edge N+1, if iReady=1.
- Per-item overhead beyond controller busy time: 3 clocks (FETCH, ISSUE, final WAIT_DONE edge).
- oDone high for the one cycle after the edge at which WAIT_DONE sees iReady=1 with index=33. oBusy falls on the same edge.
- A pending pass starts one cycle after returning to IDLE. oBusy drops for exactly one cycle between passes.
- Reset asserted mid-pass: all outputs go to reset values asynchronously, with no further oWrite. The buffer is reinitialised to spaces.
- iReady held low forever: the FSM stays in ISSUE, with no timeout.

## Test plan

- Full pass:
  - Stimulus: load "HELLO" at 0–4 and "WORLD" at 16–20. Pulse iStart. The controller model drops ready for 10 clocks per write.
  - Required: 34 writes in order 0x80(cmd), 'H','E','L','L','O', 11×0x20, 0xC0(cmd), 'W','O','R','L','D', 11×0x20.
  - Required: then one oDone pulse and oBusy=0.
- Handshake hold:
  - Stimulus: change buffer[1] mid-transfer of item 2.
  - Required: oData stays the original byte until iReady rises. The next pass shows the new byte.
- Pending collapse:
  - Stimulus: pulse iStart three times during a pass.
  - Required: exactly one additional pass (68 writes total) and two oDone pulses.
- Auto-refresh:
  - Stimulus: REFRESH_CYCLES=100, instant-ready model.
  - Required: a pass starts after 100 IDLE clocks, repeating each time. With REFRESH_CYCLES=0, no pass starts without iStart.
- Reset mid-pass:
  - Stimulus: drive Reset low at item 20, then release.
  - Required: outputs go to 0 immediately, buffer reads spaces on the next pass, and there are no spurious oWrite pulses.
- Ready stuck low:
  - Stimulus: iReady=0 from the start of a pass.
  - Required: the FSM waits in ISSUE, oWrite=0, oData=0x80, oBusy=1 indefinitely.
